generate_ca_reg_div_param: RTL

GENERATE_CA_REG_DIV_PARAM -- requirements
Module: generate_ca_reg_div_param

---
 rtl/generate_ca_reg_div_param.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/generate_ca_reg_div_param.sv
// Signed-digit capture buffer for a divider's d and q digit streams.
// Digits arrive one d and one q per accepted write; UNROLL digits pack into
// one word. The q stream lags d by one digit (q pointer = dcnt-1, saturated
// at 0), so a single trailing write completes the final q slot when full.
// Reads are registered (latency 1) and hold their data when idle.
// Build option: define CA_REG_WR_BYPASS_EN for write-first reads of a digit
// written in the same cycle; default is read-first.
module generate_ca_reg_div_param #(
    parameter int unsigned UNROLL         = 4,
    parameter int unsigned RAM_ADDR_WIDTH = 7
) (
    input  logic                      clk,
    input  logic                      async_clear_n,
    input  logic                      start,
    input  logic                      wr_enable,
    input  logic [1:0]                d_value,
    input  logic [1:0]                q_value,
    input  logic                      rd_req,
    input  logic [RAM_ADDR_WIDTH-1:0] rd_addr,
    output logic [UNROLL-1:0]         d_plus,
    output logic [UNROLL-1:0]         d_minus,
    output logic [UNROLL-1:0]         q_plus,
    output logic [UNROLL-1:0]         q_minus,
    output logic                      rd_valid,
    output logic [RAM_ADDR_WIDTH:0]   d_words,
    output logic                      full,
    output logic                      overflow
);

    localparam int unsigned LG    = $clog2(UNROLL);
    localparam int unsigned SLOTS = UNROLL * (2 ** RAM_ADDR_WIDTH);
    localparam int unsigned IDX_W = RAM_ADDR_WIDTH + LG;
    localparam int unsigned CNT_W = RAM_ADDR_WIDTH + LG + 1;
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(SLOTS);

    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             qfin_q, qfin_d;   // final q slot written while full
    logic             ovf_q, ovf_d;

    // Digit storage, flat slot index = {word, bank}
    logic [1:0] d_mem_q [SLOTS];
    logic [1:0] q_mem_q [SLOTS];

    logic             d_we, q_we;
    logic [IDX_W-1:0] d_idx, q_idx;
    logic [1:0]       d_wdata, q_wdata;

    logic [UNROLL-1:0] rd_d_plus, rd_d_minus, rd_q_plus, rd_q_minus;

    assign full     = (dcnt_q == CntFull);
    assign overflow = ovf_q;
    assign d_words  = dcnt_q[CNT_W-1:LG];

    // 2'b11 is a redundant zero; store it as 2'b00
    assign d_wdata = (d_value == 2'b11) ? 2'b00 : d_value;
    assign q_wdata = (q_value == 2'b11) ? 2'b00 : q_value;

    // Write targets: d at dcnt, q one behind; when full q sits at the last slot
    always_comb begin
        d_we  = wr_enable && !start && !full;
        q_we  = wr_enable && !start && (!full || !qfin_q);
        d_idx = dcnt_q[IDX_W-1:0];
        if (full) begin
            q_idx = '1;
        end else if (dcnt_q == '0) begin
            q_idx = '0;
        end else begin
            q_idx = dcnt_q[IDX_W-1:0] - IDX_W'(1);
        end
    end

    // Pointer and flag next state; start wins over a simultaneous write
    always_comb begin
        dcnt_d = dcnt_q;
        qfin_d = qfin_q;
        ovf_d  = ovf_q;
        if (start) begin
            dcnt_d = '0;
            qfin_d = 1'b0;
            ovf_d  = 1'b0;
        end else if (wr_enable) begin
            if (!full) begin
                dcnt_d = dcnt_q + CNT_W'(1);
            end else if (!qfin_q) begin
                qfin_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Pointer and flag registers
    always_ff @(posedge clk or negedge async_clear_n) begin
        if (!async_clear_n) begin
            dcnt_q <= '0;
            qfin_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            dcnt_q <= dcnt_d;
            qfin_q <= qfin_d;
            ovf_q  <= ovf_d;
        end
    end

    // Digit storage; cleared by reset, untouched by start
    always_ff @(posedge clk or negedge async_clear_n) begin
        if (!async_clear_n) begin
            for (int i = 0; i < int'(SLOTS); i++) begin
                d_mem_q[i] <= 2'b00;
                q_mem_q[i] <= 2'b00;
            end
        end else begin
            if (d_we) begin
                d_mem_q[d_idx] <= d_wdata;
            end
            if (q_we) begin
                q_mem_q[q_idx] <= q_wdata;
            end
        end
    end

    // Read word assembly; bank 0 (earliest digit) lands on the MSB
    always_comb begin
        rd_d_plus  = '0;
        rd_d_minus = '0;
        rd_q_plus  = '0;
        rd_q_minus = '0;
        for (int b = 0; b < int'(UNROLL); b++) begin
            logic [IDX_W-1:0] idx;
            logic [1:0]       dd;
            logic [1:0]       qd;
            idx = {rd_addr, LG'(b)};
            dd  = d_mem_q[idx];
            qd  = q_mem_q[idx];
`ifdef CA_REG_WR_BYPASS_EN
            if (d_we && (d_idx == idx)) begin
                dd = d_wdata;
            end
            if (q_we && (q_idx == idx)) begin
                qd = q_wdata;
            end
`endif
            rd_d_plus[UNROLL-1-b]  = dd[1];
            rd_d_minus[UNROLL-1-b] = dd[0];
            rd_q_plus[UNROLL-1-b]  = qd[1];
            rd_q_minus[UNROLL-1-b] = qd[0];
        end
    end

    // Registered read port; data holds when no request
    always_ff @(posedge clk or negedge async_clear_n) begin
        if (!async_clear_n) begin
            rd_valid <= 1'b0;
            d_plus   <= '0;
            d_minus  <= '0;
            q_plus   <= '0;
            q_minus  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                d_plus  <= rd_d_plus;
                d_minus <= rd_d_minus;
                q_plus  <= rd_q_plus;
                q_minus <= rd_q_minus;
            end
        end
    end

endmodule
